bridge_arbiter: RTL and testbench

Round-robin arbiter that shares one bridge input port between N_REQ senders. Each sender presents a valid/ready/data stream; the arbiter grants one at a time, forwards its beats to the bridge's valid/data_in/ready interface, and re-arbitrates after a bounded burst or when the granted sender goes idle. It sits between the sender instances and the bridge, replacing the direct sender-to-bridge connection.

---
 rtl/bridge_arb_pkg.sv | 13 +
 rtl/bridge_arbiter_rr_picker.sv | 52 +++++
 rtl/bridge_arbiter.sv | 96 +++++++++
 tb/tb_bridge_arbiter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/bridge_arb_pkg.sv
// Shared types and default sizing for the bridge input arbiter.
// WIDTH falls back to 8 when no project-wide `WIDTH is defined.
`ifndef WIDTH
`define WIDTH 8
`endif

package bridge_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_MAX_BURST = 4;
  localparam int DEF_WIDTH     = `WIDTH;
endpackage

// File: rtl/bridge_arbiter_rr_picker.sv
// Combinational winner select for the bridge arbiter.
// ARB_FIXED_PRIO_EN: lowest index wins; otherwise round-robin after last_gnt.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_gnt,
  output logic [N_REQ-1:0] win_oh,
  output logic [IW-1:0]    win_idx,
  output logic             win_any
);
  logic found;

`ifdef ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last_gnt;

  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[i]) begin
        found   = 1'b1;
        win_idx = IW'(i);
      end
    end
  end
`else
  always_comb begin
    int idx;
    idx     = 0;
    found   = 1'b0;
    win_idx = '0;
    // Walk from the slot after the previous winner, wrapping around.
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_gnt) + k) % N_REQ;
      if (!found && req[idx]) begin
        found   = 1'b1;
        win_idx = IW'(idx);
      end
    end
  end
`endif

  always_comb begin
    win_oh          = '0;
    win_oh[win_idx] = found;
  end

  assign win_any = found;
endmodule

// File: rtl/bridge_arbiter.sv
// Shares one bridge input port among N_REQ valid/ready senders, bounded bursts.
// Build with ARB_FIXED_PRIO_EN for fixed-priority instead of round-robin pick.
module bridge_arbiter
  import bridge_arb_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [N_REQ-1:0]       s_valid,
  input  logic [N_REQ*WIDTH-1:0] s_data,
  output logic [N_REQ-1:0]       s_ready,
  output logic                   m_valid,
  output logic [WIDTH-1:0]       m_data,
  input  logic                   m_ready,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_e       state, next_state;
  logic [IW-1:0]    last_gnt;
  logic [CW-1:0]    burst_cnt;
  logic [N_REQ-1:0] pick_oh;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic             cur_valid, beat, last_beat, rel;

  rr_picker #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req     (s_valid),
    .last_gnt(last_gnt),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .win_any (pick_any)
  );

  // Everything downstream keys off the registered one-hot grant, so no
  // s_valid -> gnt combinational path exists and a zero grant muxes to 0.
  assign cur_valid = |(s_valid & gnt);
  assign m_valid   = cur_valid & en;
  assign s_ready   = gnt & {N_REQ{m_ready & en}};
  assign beat      = m_valid & m_ready;
  assign last_beat = (burst_cnt == CW'(MAX_BURST - 1));
  assign busy      = (state == ARB_GRANT);

  always_comb begin
    m_data = '0;
    for (int i = 0; i < N_REQ; i++)
      m_data = m_data | (s_data[i*WIDTH +: WIDTH] & {WIDTH{gnt[i]}});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ARB_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    rel        = 1'b0;
    unique case (state)
      ARB_IDLE:  if (en && pick_any) next_state = ARB_GRANT;
      ARB_GRANT: begin
        rel = !en || !cur_valid || (beat && last_beat);
        if (rel) next_state = ARB_IDLE;
      end
      default:   next_state = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt       <= '0;
      last_gnt  <= IW'(N_REQ - 1);
      burst_cnt <= '0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (en && pick_any) begin
            gnt       <= pick_oh;
            last_gnt  <= pick_idx;
            burst_cnt <= '0;
          end
        end
        ARB_GRANT: begin
          if (rel)       gnt       <= '0;
          else if (beat) burst_cnt <= burst_cnt + CW'(1);
        end
        default: gnt <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_bridge_arbiter.sv
// Randomized bench: burst-level reference model predicts grants and beats,
// a separate monitor pops the beat scoreboard whenever the bridge accepts data.
module tb_bridge_arbiter;
  import bridge_arb_pkg::*;

  localparam int N  = 4;
  localparam int W  = DEF_WIDTH;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           rst, en, m_ready, m_valid, busy;
  logic [N-1:0]   s_valid, s_ready, gnt;
  logic [N*W-1:0] s_data;
  logic [W-1:0]   m_data;

  bridge_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .en(en), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .gnt(gnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { int src; logic [W-1:0] data; } beat_t;
  beat_t sb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: owner g holds the port until MB beats, its valid drops, or en drops;
  // every release is followed by one cycle with nobody granted.
  int st = 0, g = 0, cnt = 0, last = N - 1;
  logic [N-1:0] acc = '0;

  function automatic int pick(input logic [N-1:0] v);
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
`endif
    return -1;
  endfunction

  always @(negedge clk) begin
    logic [N-1:0] eg, er;
    logic [W-1:0] ed;
    bit beat;
    if (!rst) begin st = 0; cnt = 0; last = N - 1; end
    eg = '0; er = '0; ed = '0;
    if (st == 1) begin
      eg[g] = 1'b1;
      ed = s_data[g*W +: W];
      if (en && m_ready) er[g] = 1'b1;
    end
    beat = rst && st == 1 && en && s_valid[g] && m_ready;
    chk("gnt", 64'(gnt), 64'(eg));
    chk("busy", 64'(busy), 64'(st));
    chk("m_valid", 64'(m_valid), 64'(st == 1 && en && s_valid[g]));
    chk("s_ready", 64'(s_ready), 64'(er));
    chk("m_data", 64'(m_data), 64'(ed));
    if (beat) sb.push_back('{g, s_data[g*W +: W]});
    acc = s_valid & s_ready;
    if (rst) begin
      if (st == 0) begin
        if (en && |s_valid) begin g = pick(s_valid); last = g; cnt = 0; st = 1; end
      end else begin
        if (beat) cnt++;
        if (!en || !s_valid[g] || (beat && cnt == MB)) st = 0;
      end
    end
  end

  // Monitor: every accepted beat must match the oldest predicted beat.
  always @(negedge clk) begin
    #1;
    if (m_valid && m_ready) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL beat_unexpected: got data %0h gnt %0h expected no beat", m_data, gnt);
      end else begin
        beat_t b;
        logic [N-1:0] oh;
        b = sb.pop_front();
        oh = '0; oh[b.src] = 1'b1;
        chk("beat_data", 64'(m_data), 64'(b.data));
        chk("beat_src", 64'(gnt), 64'(oh));
      end
    end
  end

  int pv, pk, pr, pe;

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        s_valid[i] = ($urandom_range(99) < pk);
        s_data[i*W +: W] = W'($urandom);
      end else if (!s_valid[i] && $urandom_range(99) < pv) begin
        s_valid[i] = 1'b1;
        s_data[i*W +: W] = W'($urandom);
      end
    end
    m_ready = ($urandom_range(99) < pr);
    en      = ($urandom_range(99) < pe);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; m_ready = 1'b0; s_valid = '0; s_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0: begin pv = 100; pk = 100; pr = 100; pe = 100; end
        1: begin pv = 40;  pk = 60;  pr = 75;  pe = 95;  end
        2: begin pv = 60;  pk = 70;  pr = 30;  pe = 90;  end
        default: begin pv = 100; pk = 100; pr = 100; pe = 100; end
      endcase
      for (int c = 0; c < (ph == 1 ? 1500 : 400); c++) begin
        @(posedge clk);
        #1;
        if (ph == 3 && c == 22) rst = 1'b1;
        drive();
        if (ph == 3 && c == 21) begin
          #2 rst = 1'b0;
          #1;
          chk("rst_gnt", 64'(gnt), 64'(0));
          chk("rst_m_valid", 64'(m_valid), 64'(0));
          chk("rst_s_ready", 64'(s_ready), 64'(0));
        end
      end
    end
    en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
